// File: rtl/ray_sphere_seq.sv
// Ray/sphere intersection sequencer: forms L = C - O, then drives three passes through a shared
// 3-term dot-product unit (L.D, L.L, tca.tca) and reports tca, d2 and a hit flag.
module ray_sphere_seq #(
  parameter int unsigned DOT_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        ctype,
  input  logic [31:0] ox,
  input  logic [31:0] oy,
  input  logic [31:0] oz,
  input  logic [31:0] dx,
  input  logic [31:0] dy,
  input  logic [31:0] dz,
  input  logic [31:0] cx,
  input  logic [31:0] cy,
  input  logic [31:0] cz,
  input  logic [63:0] r2,
  output logic        dot_req,
  input  logic        dot_gnt,
  output logic [31:0] dot_ax,
  output logic [31:0] dot_ay,
  output logic [31:0] dot_az,
  output logic [31:0] dot_bx,
  output logic [31:0] dot_by,
  output logic [31:0] dot_bz,
  input  logic [63:0] dot_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] tca,
  output logic [63:0] d2,
  output logic        hit
);

  localparam int unsigned CntW = $clog2(DOT_LAT + 2);

  typedef enum logic [2:0] {
    StIdle, StSub, StPassLd, StPassLl, StPassTt, StEval, StDone
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2:0][31:0]      o_q, d_q, c_q, l_q, l_next, dot_a, dot_b;
  logic                  ctype_q;
  logic [63:0]           r2_q, ll_q, d2_q;
  logic [31:0]           tca_q;
  logic                  hit_q;
  logic                  pass_done;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      l_next[i] = (ctype_q ? {c_q[i][15:0], 16'h0000} : c_q[i]) - o_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    dot_req   = 1'b0;
    out_valid = 1'b0;
    pass_done = 1'b0;
    dot_a     = '0;
    dot_b     = '0;
    unique case (state_q)
      StIdle: begin
        in_ready = reset_n;
        if (in_valid) state_d = StSub;
      end
      StSub: state_d = StPassLd;
      StPassLd, StPassLl, StPassTt: begin
        dot_req = 1'b1;
        case (state_q)
          StPassLd: begin dot_a = l_q; dot_b = d_q; end
          StPassLl: begin dot_a = l_q; dot_b = l_q; end
          default:  begin dot_a[0] = tca_q; dot_b[0] = tca_q; end
        endcase
        // Any gap in the grant restarts the count; operands stay put meanwhile.
        if (!dot_gnt) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(DOT_LAT)) begin
          pass_done = 1'b1;
          cnt_d     = '0;
          case (state_q)
            StPassLd: state_d = StPassLl;
            StPassLl: state_d = StPassTt;
            default:  state_d = StEval;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEval: state_d = StDone;
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      o_q     <= '0;
      d_q     <= '0;
      c_q     <= '0;
      l_q     <= '0;
      ctype_q <= 1'b0;
      r2_q    <= '0;
      ll_q    <= '0;
      d2_q    <= '0;
      tca_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && in_valid) begin
        o_q     <= {oz, oy, ox};
        d_q     <= {dz, dy, dx};
        c_q     <= {cz, cy, cx};
        ctype_q <= ctype;
        r2_q    <= r2;
      end
      if (state_q == StSub) l_q <= l_next;
      if (pass_done) begin
        case (state_q)
          StPassLd: tca_q <= dot_result[47:16];
          StPassLl: ll_q  <= dot_result;
          default:  d2_q  <= ll_q - dot_result;
        endcase
      end
      if (state_q == StEval) hit_q <= ~tca_q[31] & ($signed(d2_q) <= $signed(r2_q));
    end
  end

  assign dot_ax = dot_a[0];
  assign dot_ay = dot_a[1];
  assign dot_az = dot_a[2];
  assign dot_bx = dot_b[0];
  assign dot_by = dot_b[1];
  assign dot_bz = dot_b[2];
  assign tca    = tca_q;
  assign d2     = d2_q;
  assign hit    = hit_q;

endmodule
